// File: rtl/pcm_freq_meter.sv
// pcm_freq_meter: counts valid PCM samples spanning N rising zero crossings (with hysteresis)
// and reports that count together with the positive peak, or a timeout flag.
module pcm_freq_meter #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int HYST       = 256,
  parameter int NPER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid_i,
  input  logic [DATA_WIDTH-1:0] pcm_i,
  input  logic                  start_i,
  input  logic [NPER_WIDTH-1:0] nper_i,
  input  logic [CNT_WIDTH-1:0]  timeout_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [CNT_WIDTH-1:0]  period_cnt_o,
  output logic [DATA_WIDTH-1:0] peak_o
);
  typedef enum logic [2:0] {IDLE, ARM, SYNC, MEASURE, DONE} state_t;
  localparam logic signed [DATA_WIDTH:0] HYST_P = (DATA_WIDTH+1)'(HYST);
  localparam logic signed [DATA_WIDTH:0] HYST_N = -HYST_P;
  state_t state_q, state_d;
  logic                  level_q, level_d;
  logic [NPER_WIDTH-1:0] nper_q, nper_d, ecnt_q, ecnt_d;
  logic [CNT_WIDTH-1:0]  tmo_q, tmo_d, tcnt_q, tcnt_d, scnt_q, scnt_d;
  logic [DATA_WIDTH-1:0] peak_q, peak_d;
  logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
  logic [DATA_WIDTH-1:0] res_peak_q, res_peak_d;
  logic                  res_tmo_q, res_tmo_d;
  logic signed [DATA_WIDTH:0] pcm_x;
  logic is_hi, is_lo, rise, accept, active, tmo_hit, final_edge;
  logic [CNT_WIDTH-1:0]  tcnt_inc, scnt_sat;
  logic [DATA_WIDTH-1:0] peak_max;
  // Sign-extend one bit so -HYST is representable exactly in the compare.
  assign pcm_x      = {pcm_i[DATA_WIDTH-1], pcm_i};
  assign is_hi      = pcm_x >= HYST_P;
  assign is_lo      = pcm_x <= HYST_N;
  assign rise       = sample_valid_i && !level_q && is_hi;
  assign accept     = start_i && (state_q == IDLE || state_q == DONE);
  assign active     = state_q == ARM || state_q == SYNC || state_q == MEASURE;
  assign tcnt_inc   = tcnt_q + CNT_WIDTH'(1);
  assign tmo_hit    = active && sample_valid_i && tmo_q != '0 && tcnt_inc == tmo_q;
  assign final_edge = state_q == MEASURE && rise && (ecnt_q + NPER_WIDTH'(1)) == nper_q;
  assign scnt_sat   = (&scnt_q) ? scnt_q : scnt_q + CNT_WIDTH'(1);
  assign peak_max   = ($signed(pcm_i) > $signed(peak_q)) ? pcm_i : peak_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      level_q    <= 1'b0;
      nper_q     <= '0;
      ecnt_q     <= '0;
      tmo_q      <= '0;
      tcnt_q     <= '0;
      scnt_q     <= '0;
      peak_q     <= '0;
      res_cnt_q  <= '0;
      res_peak_q <= '0;
      res_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      nper_q     <= nper_d;
      ecnt_q     <= ecnt_d;
      tmo_q      <= tmo_d;
      tcnt_q     <= tcnt_d;
      scnt_q     <= scnt_d;
      peak_q     <= peak_d;
      res_cnt_q  <= res_cnt_d;
      res_peak_q <= res_peak_d;
      res_tmo_q  <= res_tmo_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept ? ARM : IDLE;
      ARM:        state_d = tmo_hit ? DONE : (sample_valid_i && is_lo) ? SYNC : ARM;
      SYNC:       state_d = tmo_hit ? DONE : rise ? MEASURE : SYNC;
      MEASURE:    state_d = (final_edge || tmo_hit) ? DONE : MEASURE;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    level_d    = accept ? 1'b0 : !sample_valid_i ? level_q : is_hi ? 1'b1 : is_lo ? 1'b0 : level_q;
    nper_d     = accept ? ((nper_i == '0) ? NPER_WIDTH'(1) : nper_i) : nper_q;
    tmo_d      = accept ? timeout_i : tmo_q;
    tcnt_d     = accept ? '0 : (active && sample_valid_i) ? tcnt_inc : tcnt_q;
    scnt_d     = scnt_q;
    ecnt_d     = ecnt_q;
    peak_d     = peak_q;
    res_cnt_d  = res_cnt_q;
    res_peak_d = res_peak_q;
    res_tmo_d  = res_tmo_q;
    if (state_q == SYNC && rise) begin
      scnt_d = '0;
      ecnt_d = '0;
      peak_d = pcm_i;
    end
    if (state_q == MEASURE && sample_valid_i) begin
      scnt_d = scnt_sat;
      peak_d = peak_max;
      ecnt_d = ecnt_q + NPER_WIDTH'(rise);
    end
    // A final edge on the timeout sample still yields a valid result.
    if (final_edge) begin
      res_cnt_d  = scnt_sat;
      res_peak_d = peak_max;
      res_tmo_d  = 1'b0;
    end else if (tmo_hit) begin
      res_cnt_d  = '0;
      res_peak_d = '0;
      res_tmo_d  = 1'b1;
    end
  end
  always_comb begin
    busy_o = active;
    done_o = state_q == DONE;
  end
  assign timeout_o    = res_tmo_q;
  assign period_cnt_o = res_cnt_q;
  assign peak_o       = res_peak_q;
endmodule
